// File: rtl/led_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan feeder.
// Imported by the prescaler and the top-level scan controller.
package led_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/led_scan_prescaler.sv
// Refresh prescaler: counts one digit slot and flags the slot wrap.
// Holds its count while scanning is disabled.
module led_scan_prescaler #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  output logic [DIV_WIDTH-1:0] o_cnt,
  output logic                 o_wrap
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_term;

  assign w_term = (r_cnt == DIV_WIDTH'(DIV_MAX));
  assign o_cnt  = r_cnt;
  assign o_wrap = i_en & w_term;

  // Slot counter: advance while enabled, wrap at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Four-digit scan controller: double-buffered display word, digit
// select rotation and per-slot anti-ghosting blank window.
module led_scan_ctrl
  import led_scan_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [15:0]      wr_data,
  output logic             wr_ack,
  output logic [3:0]       ain,
  output logic [3:0]       bin,
  output logic [3:0]       cin,
  output logic [3:0]       din,
  output logic [SEL_W-1:0] sel,
  output logic             blank,
  output logic             frame_tick
);

  logic [DIV_WIDTH-1:0] w_cnt;
  logic                 w_wrap;
  logic                 w_frame;
  logic                 w_reach;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [15:0]          r_active;
  logic [15:0]          r_pending;
  logic                 r_pend_valid;
  logic                 r_wr_ack;
  logic                 r_frame_tick;

  led_scan_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_MAX   (DIV_MAX)
  ) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .o_cnt  (w_cnt),
    .o_wrap (w_wrap)
  );

  assign w_frame = w_wrap && (r_sel == SEL_W'(NUM_DIGITS - 1));

  // Will the count after this edge be past the blank window?
  always_comb begin
    w_reach = 1'b0;
    if (w_wrap) begin
      w_reach = (BLANK_CYCLES == 0);
    end else begin
      w_reach = (int'(w_cnt) + 1 >= BLANK_CYCLES);
    end
  end

  // Next-state logic for the blank/show window.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BLANK: begin
        if (en && w_reach) w_state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        if (!en) begin
          w_state_nxt = ST_BLANK;
        end else if (w_wrap && BLANK_CYCLES > 0) begin
          w_state_nxt = ST_BLANK;
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // State register; blank window starts in lockstep with sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BLANK;
    else        r_state <= w_state_nxt;
  end

  // Digit select advances on each slot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sel <= '0;
    else if (w_wrap) r_sel <= r_sel + 1'b1;
  end

  // Double buffer: new words land in active only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_wr_ack     <= wr_en;
      r_frame_tick <= 1'b0;
      if (wr_en) r_pending <= wr_data;
      if (w_frame && (wr_en || r_pend_valid)) begin
        r_active     <= wr_en ? wr_data : r_pending;
        r_pend_valid <= 1'b0;
        r_frame_tick <= 1'b1;
      end else if (wr_en) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign ain        = r_active[3:0];
  assign bin        = r_active[7:4];
  assign cin        = r_active[11:8];
  assign din        = r_active[15:12];
  assign sel        = r_sel;
  assign blank      = (r_state == ST_BLANK);
  assign wr_ack     = r_wr_ack;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Upstream feeder for the 4-digit seven-segment decoder/mux. It holds a 16-bit display word written by the AVR-side bus logic and generates the digit-select scan. It presents the four nibbles plus a select code to the decoder. Double-buffering applies new words only at frame boundaries (no tearing), and a per-digit blanking window suppresses ghosting.

Parameters:
DIV_WIDTH, 16, width of refresh prescaler counter
DIV_MAX, 49999, prescaler terminal count; one digit slot = DIV_MAX+1 clocks (1 kHz/digit at 50 MHz)
BLANK_CYCLES, 64, clocks at start of each slot with blank asserted; legal range 0..DIV_MAX

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low freezes scan and forces blank
wr_en  in  1  single-cycle write strobe for display word
wr_data  in  16  display word; [3:0] digit0 ... [15:12] digit3
wr_ack  out  1  one-cycle pulse, cycle after accepted write
ain  out  4  active[3:0] (digit 0)
bin  out  4  active[7:4] (digit 1)
cin  out  4  active[11:8] (digit 2)
din  out  4  active[15:12] (digit 3)
sel  out  2  current digit select, 0..3
blank  out  1  high = drive no digit (decoder digit enables to be gated off)
frame_tick  out  1  one-cycle pulse when a frame boundary is taken

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs registered.
- Reset values: cnt=0, sel=0, active=0, pending=0, pend_valid=0, wr_ack=0, frame_tick=0, blank=1, state=BLANK.
- Prescaler: when en=1, cnt increments each clock; at cnt==DIV_MAX it wraps to 0 and sel advances (3 wraps to 0). When en=0, cnt and sel hold.
- FSM, two states:
  - BLANK: blank=1. Goes to SHOW when en=1 and cnt==BLANK_CYCLES-1. Goes straight to SHOW at slot start if BLANK_CYCLES=0.
  - SHOW: blank=0. Goes to BLANK on slot wrap (cnt==DIV_MAX) if BLANK_CYCLES>0, or immediately when en falls.
  - en=0 forces BLANK. On en rising, scanning resumes from the held cnt/sel. If that cnt is already >= BLANK_CYCLES, move to SHOW the next cycle.
- Write path: wr_en=1 captures wr_data into pending and sets pend_valid. wr_ack pulses on the next cycle. Back-to-back writes are all acked; the last one wins.
- Frame boundary: en=1, cnt==DIV_MAX and sel==3. If pend_valid, active<=pending, pend_valid<=0, and frame_tick pulses next cycle. With no pending data, no frame_tick and active is unchanged.
- Simultaneous wr_en and frame boundary: wr_data goes directly into active. pend_valid clears, frame_tick pulses, and wr_ack pulses.
- Writes while en=0 stay pending until the first boundary after resume.
- ain..din, sel and blank change on the same clock edge, so the decoder never sees a new digit's data on an old select.
- Reset asserted mid-frame returns all state to reset values immediately. Pending data is discarded.

Decomposition:
- Shared package: FSM state encodings (ST_BLANK, ST_SHOW), digit count constant NUM_DIGITS=4, select width 2.
- One natural sub-module: led_scan_prescaler (cnt, slot wrap strobe, en hold). Parent holds the FSM, buffers and sel.

Test Plan:
- Reset / idle (DIV_MAX=9, BLANK_CYCLES=2, en=1): expect sel sequence 0,1,2,3,0 every 10 clocks. blank is high for 2 clocks at each slot start, low for 8. ain..din=0. No frame_tick.
- Buffered write: wr_data=16'h1234 in slot sel=1 → wr_ack pulses one cycle later; outputs stay 0 until the boundary. One cycle after the boundary: ain=4, bin=3, cin=2, din=1 and frame_tick=1 for one cycle.
- Write collision: wr_en with 16'hBEEF exactly at cnt=9, sel=3 → next cycle active=BEEF (ain=F, din=B), frame_tick=1, wr_ack=1, pend_valid=0.
- Last-write-wins: writes 16'h1111 then 16'h2222 in consecutive cycles mid-frame → two wr_ack pulses; after the boundary active=2222.
- Enable gating: drop en at cnt=5, sel=2 for 20 clocks → blank=1, cnt/sel frozen. After resume, blank falls the next cycle and the slot completes at cnt=9.
- Async reset mid-frame with pending data: rst_n low between clock edges → outputs reach reset values without a clock edge. After release, the pending word never appears and no frame_tick occurs.
